// File: rtl/traffic_phase_timer.sv
// Traffic-light phase sequencer: six-phase ring with a per-phase BCD countdown
// of seconds remaining, paced by a prescaler tick. Every output is a flop.
module traffic_phase_timer #(
  parameter int TICK_DIV   = 50_000_000,
  parameter int GREEN_SEC  = 25,
  parameter int YELLOW_SEC = 3,
  parameter int ALLRED_SEC = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic [2:0] ns_lamp,
  output logic [2:0] ew_lamp,
  output logic [3:0] cnt_tens,
  output logic [3:0] cnt_ones,
  output logic       tick,
  output logic [2:0] dbg_phase
);

  typedef enum logic [2:0] {
    NS_GRN = 3'd0,
    NS_YEL = 3'd1,
    RED1   = 3'd2,
    EW_GRN = 3'd3,
    EW_YEL = 3'd4,
    RED2   = 3'd5
  } phase_t;

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  localparam logic [3:0] GRN_T = 4'(GREEN_SEC / 10);
  localparam logic [3:0] GRN_O = 4'(GREEN_SEC % 10);
  localparam logic [3:0] YEL_T = 4'(YELLOW_SEC / 10);
  localparam logic [3:0] YEL_O = 4'(YELLOW_SEC % 10);
  localparam logic [3:0] RED_T = 4'(ALLRED_SEC / 10);
  localparam logic [3:0] RED_O = 4'(ALLRED_SEC % 10);

  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_G = 3'b001;

  generate
    if (TICK_DIV < 2) begin : g_bad_div
      $error("traffic_phase_timer: TICK_DIV must be >= 2");
    end
    if (GREEN_SEC < 1 || GREEN_SEC > 99) begin : g_bad_green
      $error("traffic_phase_timer: GREEN_SEC must be 1..99");
    end
    if (YELLOW_SEC < 1 || YELLOW_SEC > 99) begin : g_bad_yellow
      $error("traffic_phase_timer: YELLOW_SEC must be 1..99");
    end
    if (ALLRED_SEC < 1 || ALLRED_SEC > 99) begin : g_bad_allred
      $error("traffic_phase_timer: ALLRED_SEC must be 1..99");
    end
  endgenerate

  phase_t        phase, phase_nx;
  logic [PW-1:0] presc, presc_nx;
  logic [3:0]    tens_nx, ones_nx;
  logic          tick_cond;
  logic [2:0]    ns_nx, ew_nx;

  function automatic phase_t ring_next(input phase_t p);
    case (p)
      NS_GRN:  ring_next = NS_YEL;
      NS_YEL:  ring_next = RED1;
      RED1:    ring_next = EW_GRN;
      EW_GRN:  ring_next = EW_YEL;
      EW_YEL:  ring_next = RED2;
      default: ring_next = NS_GRN;
    endcase
  endfunction

  // Length of a phase as {tens, ones} BCD.
  function automatic logic [7:0] phase_len(input phase_t p);
    case (p)
      NS_GRN, EW_GRN: phase_len = {GRN_T, GRN_O};
      NS_YEL, EW_YEL: phase_len = {YEL_T, YEL_O};
      default:        phase_len = {RED_T, RED_O};
    endcase
  endfunction

  assign tick_cond = en && (presc == PRESC_LAST);
  assign dbg_phase = phase;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase    <= RED2;
      presc    <= '0;
      cnt_tens <= RED_T;
      cnt_ones <= RED_O;
      tick     <= 1'b0;
      ns_lamp  <= LAMP_R;
      ew_lamp  <= LAMP_R;
    end else begin
      phase    <= phase_nx;
      presc    <= presc_nx;
      cnt_tens <= tens_nx;
      cnt_ones <= ones_nx;
      tick     <= tick_cond;
      ns_lamp  <= ns_nx;
      ew_lamp  <= ew_nx;
    end
  end

  // Next-state logic: prescaler, BCD countdown and phase advance
  always_comb begin
    phase_nx = phase;
    presc_nx = presc;
    tens_nx  = cnt_tens;
    ones_nx  = cnt_ones;
    if (en) begin
      presc_nx = (presc == PRESC_LAST) ? '0 : presc + 1'b1;
    end
    if (tick_cond) begin
      if (cnt_tens == 4'd0 && cnt_ones == 4'd1) begin
        phase_nx           = ring_next(phase);
        {tens_nx, ones_nx} = phase_len(phase_nx);
      end else if (cnt_ones == 4'd0) begin
        ones_nx = 4'd9;
        tens_nx = cnt_tens - 4'd1;
      end else begin
        ones_nx = cnt_ones - 4'd1;
      end
    end
  end

  // Output logic: lamps decoded from the next phase so they register alongside it
  always_comb begin
    ns_nx = LAMP_R;
    ew_nx = LAMP_R;
    case (phase_nx)
      NS_GRN:  ns_nx = LAMP_G;
      NS_YEL:  ns_nx = LAMP_Y;
      EW_GRN:  ew_nx = LAMP_G;
      EW_YEL:  ew_nx = LAMP_Y;
      default: begin
        ns_nx = LAMP_R;
        ew_nx = LAMP_R;
      end
    endcase
  end

endmodule

// File: tb/tb_traffic_phase_timer.sv
// Directed bench for traffic_phase_timer with TICK_DIV=4, GREEN=12, YELLOW=3,
// ALLRED=2; expected phases and counts come from a small decimal ring model.
module tb_traffic_phase_timer;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [2:0] ns_lamp;
  logic [2:0] ew_lamp;
  logic [3:0] cnt_tens;
  logic [3:0] cnt_ones;
  logic       tick;
  logic [2:0] dbg_phase;

  int tests_run = 0;
  int tests_failed = 0;

  // Ring model: index 0..5 = NS_GRN, NS_YEL, RED1, EW_GRN, EW_YEL, RED2
  int         len_tab[6] = '{12, 3, 2, 12, 3, 2};
  logic [2:0] ns_tab[6]  = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100};
  logic [2:0] ew_tab[6]  = '{3'b100, 3'b100, 3'b100, 3'b001, 3'b010, 3'b100};
  int m_ph;
  int m_cnt;

  traffic_phase_timer #(
    .TICK_DIV(4), .GREEN_SEC(12), .YELLOW_SEC(3), .ALLRED_SEC(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .ns_lamp(ns_lamp), .ew_lamp(ew_lamp),
    .cnt_tens(cnt_tens), .cnt_ones(cnt_ones),
    .tick(tick), .dbg_phase(dbg_phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clk1();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_tick(input int max, output int cyc, output bit ok);
    cyc = 0;
    ok = 1'b0;
    while (cyc < max) begin
      clk1();
      cyc++;
      if (ns_lamp != 3'b100 && ew_lamp != 3'b100) begin
        tests_run++;
        tests_failed++;
        $display("FAIL safety: ns=%b ew=%b both non-red", ns_lamp, ew_lamp);
      end
      if (tick) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic model_tick();
    if (m_cnt == 1) begin
      m_ph  = (m_ph + 1) % 6;
      m_cnt = len_tab[m_ph];
    end else begin
      m_cnt = m_cnt - 1;
    end
  endtask

  // One modelled tick, then compare count, lamps and phase against the model.
  task automatic tick_and_check(input string name);
    int cyc;
    bit ok;
    wait_tick(8, cyc, ok);
    model_tick();
    tests_run++;
    if (!ok || cyc != 4) begin
      tests_failed++;
      $display("FAIL %s period: got %0d clks (ok=%0d), need 4", name, cyc, ok);
    end
    tests_run++;
    if (cnt_tens !== 4'(m_cnt / 10) || cnt_ones !== 4'(m_cnt % 10)) begin
      tests_failed++;
      $display("FAIL %s count: got %0d%0d, need %0d", name, cnt_tens, cnt_ones, m_cnt);
    end
    tests_run++;
    if (ns_lamp !== ns_tab[m_ph] || ew_lamp !== ew_tab[m_ph] || dbg_phase !== 3'(m_ph)) begin
      tests_failed++;
      $display("FAIL %s lamps: got ns=%b ew=%b ph=%0d, need ns=%b ew=%b ph=%0d",
               name, ns_lamp, ew_lamp, dbg_phase, ns_tab[m_ph], ew_tab[m_ph], m_ph);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en    = 1'b0;
    clk1();
    clk1();
    tests_run++;
    if (ns_lamp !== 3'b100 || ew_lamp !== 3'b100) begin
      tests_failed++;
      $display("FAIL reset_lamps: got ns=%b ew=%b, need 100/100", ns_lamp, ew_lamp);
    end
    tests_run++;
    if (cnt_tens !== 4'd0 || cnt_ones !== 4'd2) begin
      tests_failed++;
      $display("FAIL reset_count: got %0d/%0d, need 0/2", cnt_tens, cnt_ones);
    end
    tests_run++;
    if (tick !== 1'b0 || dbg_phase !== 3'd5) begin
      tests_failed++;
      $display("FAIL reset_state: got tick=%b ph=%0d, need 0/5", tick, dbg_phase);
    end
    m_ph  = 5;
    m_cnt = 2;
  endtask

  task automatic test_tick_period();
    rst_n = 1'b1;
    en    = 1'b1;
    tick_and_check("first_tick");
    tick_and_check("enter_ns_grn");
  endtask

  task automatic test_full_cycle();
    for (int i = 0; i < 34; i++) tick_and_check("ring");
    tests_run++;
    if (dbg_phase !== 3'd0 || cnt_tens !== 4'd1 || cnt_ones !== 4'd2) begin
      tests_failed++;
      $display("FAIL ring_wrap: got ph=%0d %0d%0d, need ph=0 12", dbg_phase, cnt_tens, cnt_ones);
    end
  endtask

  task automatic test_borrow();
    tick_and_check("bcd_11");
    tick_and_check("bcd_10");
    tick_and_check("bcd_borrow");
    tests_run++;
    if (cnt_tens !== 4'd0 || cnt_ones !== 4'd9) begin
      tests_failed++;
      $display("FAIL borrow: got %0d/%0d, need 0/9", cnt_tens, cnt_ones);
    end
  endtask

  task automatic test_freeze();
    int cyc;
    bit ok;
    for (int i = 0; i < 10; i++) tick_and_check("to_yellow");
    // Now NS_YEL showing 02 with the prescaler at 0; advance it to 1.
    clk1();
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      clk1();
      tests_run++;
      if (tick !== 1'b0 || ns_lamp !== 3'b010 || ew_lamp !== 3'b100 ||
          cnt_tens !== 4'd0 || cnt_ones !== 4'd2 || dbg_phase !== 3'd1) begin
        tests_failed++;
        $display("FAIL freeze: got tick=%b ns=%b ew=%b %0d%0d ph=%0d, need 0 010 100 02 ph=1",
                 tick, ns_lamp, ew_lamp, cnt_tens, cnt_ones, dbg_phase);
      end
    end
    en = 1'b1;
    wait_tick(8, cyc, ok);
    model_tick();
    tests_run++;
    if (!ok || cyc != 3) begin
      tests_failed++;
      $display("FAIL resume_latency: got %0d clks (ok=%0d), need 3", cyc, ok);
    end
    tests_run++;
    if (cnt_tens !== 4'd0 || cnt_ones !== 4'd1 || ns_lamp !== 3'b010) begin
      tests_failed++;
      $display("FAIL resume_count: got %0d%0d ns=%b, need 01 ns=010", cnt_tens, cnt_ones, ns_lamp);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 8; i++) tick_and_check("to_ew_grn");
    tests_run++;
    if (dbg_phase !== 3'd3 || cnt_tens !== 4'd0 || cnt_ones !== 4'd7 || ew_lamp !== 3'b001) begin
      tests_failed++;
      $display("FAIL pre_reset: got ph=%0d %0d%0d ew=%b, need ph=3 07 ew=001",
               dbg_phase, cnt_tens, cnt_ones, ew_lamp);
    end
    rst_n = 1'b0;
    clk1();
    rst_n = 1'b1;
    tests_run++;
    if (dbg_phase !== 3'd5 || cnt_tens !== 4'd0 || cnt_ones !== 4'd2 ||
        ns_lamp !== 3'b100 || ew_lamp !== 3'b100 || tick !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_reset: got ph=%0d %0d%0d ns=%b ew=%b tick=%b, need ph=5 02 100 100 0",
               dbg_phase, cnt_tens, cnt_ones, ns_lamp, ew_lamp, tick);
    end
    m_ph  = 5;
    m_cnt = 2;
    tick_and_check("after_reset");
    tick_and_check("after_reset_grn");
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    test_reset();
    test_tick_period();
    test_full_cycle();
    test_borrow();
    test_freeze();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
